// File: rtl/scene_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scene_pkg
// Description : Shared scene encodings and default timing constants for the
//               scene controller and the segment timer that consumes its
//               scene code.
// Revision    : 1.0 - initial release
// ============================================================================
package scene_pkg;

  // Scene codes as seen on the 4-bit state bus; codes 6..15 are never driven.
  typedef enum logic [3:0] {
    SC_START = 4'd0,
    SC_PLAY  = 4'd1,
    SC_LOSE  = 4'd2,
    SC_WIN   = 4'd3,
    SC_BOSS  = 4'd4,
    SC_PAUSE = 4'd5
  } scene_t;

  localparam int unsigned DEF_CLK_HZ     = 100_000_000;
  localparam int unsigned DEF_RESULT_SEC = 5;
  localparam int unsigned DEF_HOLDOFF    = 1_000_000;

  // WIN and LOSE are the two result scenes that run the auto-return timer.
  function automatic logic is_result(scene_t s);
    return (s == SC_WIN) || (s == SC_LOSE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/scene_ctrl_btn_edge.sv
`default_nettype none
// ============================================================================
// Module      : btn_edge
// Description : Two-flop synchronizer plus rising-edge detector for one raw
//               asynchronous push button.
// Ports       : clk     - system clock
//               rst     - asynchronous active-high reset
//               btn_raw - raw asynchronous button level
//               rise    - one-cycle pulse after a synchronized 0->1 change
// Revision    : 1.0 - initial release
// ============================================================================
module btn_edge
  import scene_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic rise
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  // Combinational so the scene register consumes it on the 3rd sampling edge.
  assign rise = sync2_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/scene_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : scene_ctrl
// Description : Game scene sequencer (START/PLAY/BOSS/WIN/LOSE and optional
//               PAUSE) with button holdoff and a result-screen auto-return
//               timer. The pause feature is built only when the macro
//               SCENE_PAUSE_EN is defined.
// Ports       : clk, rst     - system clock, asynchronous active-high reset
//               btn_start    - raw start/confirm button
//               btn_pause    - raw pause button (unused without SCENE_PAUSE_EN)
//               player_dead, boss_zone, boss_dead - synchronous 1-cycle pulses
//               state        - registered scene code
//               scene_enter  - pulse in the first cycle of each new scene
//               timer_run    - high while in PLAY or BOSS
// Revision    : 1.0 - initial release
// ============================================================================
module scene_ctrl
  import scene_pkg::*;
#(
  parameter int unsigned CLK_HZ     = DEF_CLK_HZ,
  parameter int unsigned RESULT_SEC = DEF_RESULT_SEC,
  parameter int unsigned HOLDOFF    = DEF_HOLDOFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       player_dead,
  input  logic       boss_zone,
  input  logic       boss_dead,
  output logic [3:0] state,
  output logic       scene_enter,
  output logic       timer_run
);

  localparam int unsigned PRE_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned SEC_W  = $clog2(RESULT_SEC + 1);
  localparam int unsigned HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLK_HZ - 1);
  localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(RESULT_SEC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF - 1);

  scene_t              state_q, state_d;
  logic                scene_enter_q, scene_enter_d;
  logic                timer_run_q, timer_run_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [SEC_W-1:0]    sec_q, sec_d;

  logic start_rise;
  logic pause_rise;
  logic start_ok;
  logic pause_ok;
  logic expire;
  logic entering;

  btn_edge u_start_edge (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_start),
    .rise    (start_rise)
  );

`ifdef SCENE_PAUSE_EN
  scene_t saved_q, saved_d;

  btn_edge u_pause_edge (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_pause),
    .rise    (pause_rise)
  );

  // Remember which play scene was left so the second pause edge can resume it.
  always_comb begin
    saved_d = saved_q;
    if ((state_d == SC_PAUSE) && (state_q != SC_PAUSE)) begin
      saved_d = state_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      saved_q <= SC_PLAY;
    end else begin
      saved_q <= saved_d;
    end
  end
`else
  logic unused_btn_pause;
  assign unused_btn_pause = btn_pause;
  assign pause_rise       = 1'b0;
`endif

  // Button edges only count once the post-entry holdoff window has drained.
  assign start_ok = start_rise && (hold_q == '0);
  assign pause_ok = pause_rise && (hold_q == '0);

  // Fires on the edge at which the seconds count would reach RESULT_SEC.
  assign expire = is_result(state_q) && (pre_q == PRE_LAST) && (sec_q == SEC_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      SC_START: begin
        if (start_ok) state_d = SC_PLAY;
      end
      SC_PLAY: begin
        if (player_dead)    state_d = SC_LOSE;
        else if (boss_zone) state_d = SC_BOSS;
        else if (pause_ok)  state_d = SC_PAUSE;
      end
      SC_BOSS: begin
        if (player_dead)    state_d = SC_LOSE;
        else if (boss_dead) state_d = SC_WIN;
        else if (pause_ok)  state_d = SC_PAUSE;
      end
      SC_WIN, SC_LOSE: begin
        if (start_ok || expire) state_d = SC_START;
      end
`ifdef SCENE_PAUSE_EN
      SC_PAUSE: begin
        if (pause_ok) state_d = saved_q;
      end
`endif
      default: state_d = SC_START;
    endcase
  end

  assign entering = (state_d != state_q);

  always_comb begin
    scene_enter_d = entering;
    timer_run_d   = (state_d == SC_PLAY) || (state_d == SC_BOSS);

    if (entering)            hold_d = HOLD_LOAD;
    else if (hold_q != '0)   hold_d = hold_q - 1'b1;
    else                     hold_d = hold_q;

    pre_d = pre_q;
    sec_d = sec_q;
    if (entering) begin
      pre_d = '0;
      sec_d = '0;
    end else if (is_result(state_q)) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        sec_d = sec_q + 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= SC_START;
      scene_enter_q <= 1'b0;
      timer_run_q   <= 1'b0;
      hold_q        <= HOLD_LOAD;
      pre_q         <= '0;
      sec_q         <= '0;
    end else begin
      state_q       <= state_d;
      scene_enter_q <= scene_enter_d;
      timer_run_q   <= timer_run_d;
      hold_q        <= hold_d;
      pre_q         <= pre_d;
      sec_q         <= sec_d;
    end
  end

  assign state       = state_q;
  assign scene_enter = scene_enter_q;
  assign timer_run   = timer_run_q;

endmodule
`default_nettype wire

// File: tb/tb_scene_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_scene_ctrl
// Description : Self-checking bench for scene_ctrl (CLK_HZ=10, RESULT_SEC=2,
//               HOLDOFF=4). A scene-level model tracks cycles-since-entry and
//               button sample history; directed sequences add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scene_ctrl;

  localparam int CLK_HZ     = 10;
  localparam int RESULT_SEC = 2;
  localparam int HOLDOFF    = 4;
`ifdef SCENE_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_pause = 1'b0;
  logic       player_dead = 1'b0;
  logic       boss_zone = 1'b0;
  logic       boss_dead = 1'b0;
  logic [3:0] state;
  logic       scene_enter;
  logic       timer_run;

  int n_tests = 0;
  int n_fail  = 0;

  scene_ctrl #(
    .CLK_HZ     (CLK_HZ),
    .RESULT_SEC (RESULT_SEC),
    .HOLDOFF    (HOLDOFF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_start   (btn_start),
    .btn_pause   (btn_pause),
    .player_dead (player_dead),
    .boss_zone   (boss_zone),
    .boss_dead   (boss_dead),
    .state       (state),
    .scene_enter (scene_enter),
    .timer_run   (timer_run)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_age counts clock edges since the current scene was entered (0 in the
  // entry cycle). A button edge reaches the scene logic at edge k when the
  // button was sampled high at edge k-2 and low at edge k-3.
  int m_scene = 0;
  int m_saved = 1;
  int m_age   = 0;
  bit m_enter = 1'b0;
  bit m_run   = 1'b0;
  bit [2:0] sh = 3'b000;  // sh[i] = btn_start sampled i+1 edges ago
  bit [2:0] ph = 3'b000;

  task automatic model_step();
    bit s_edge, p_edge, ok;
    int nxt;
    s_edge = sh[1] & ~sh[2];
    p_edge = ph[1] & ~ph[2];
    ok     = (m_age >= HOLDOFF - 1);
    nxt    = m_scene;
    case (m_scene)
      0: if (s_edge && ok) nxt = 1;
      1: begin
        if (player_dead)                  nxt = 2;
        else if (boss_zone)               nxt = 4;
        else if (PAUSE_EN && p_edge && ok) begin m_saved = 1; nxt = 5; end
      end
      4: begin
        if (player_dead)                  nxt = 2;
        else if (boss_dead)               nxt = 3;
        else if (PAUSE_EN && p_edge && ok) begin m_saved = 4; nxt = 5; end
      end
      2, 3: if ((s_edge && ok) || (m_age == CLK_HZ * RESULT_SEC - 1)) nxt = 0;
      5: if (p_edge && ok) nxt = m_saved;
      default: nxt = 0;
    endcase
    m_enter = (nxt != m_scene);
    if (m_enter)              m_age = 0;
    else if (m_age < 1000000) m_age = m_age + 1;
    m_scene = nxt;
    m_run   = (nxt == 1) || (nxt == 4);
    sh = {sh[1], sh[0], btn_start};
    ph = {ph[1], ph[0], btn_pause};
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_scene = 0; m_age = 0; m_enter = 1'b0; m_run = 1'b0;
        m_saved = 1; sh = 3'b000; ph = 3'b000;
      end else begin
        model_step();
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    check("model_state", {28'd0, state}, m_scene);
    check("model_enter", {31'd0, scene_enter}, {31'd0, m_enter});
    check("model_run",   {31'd0, timer_run}, {31'd0, m_run});
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic press_start();
    btn_start = 1'b1; step(3); btn_start = 1'b0; step(2);
  endtask

  task automatic to_win();
    press_start();
    boss_zone = 1'b1; step(1); boss_zone = 1'b0;
    boss_dead = 1'b1; step(1); boss_dead = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    step(2);
    check("reset_state", {28'd0, state}, 0);
    check("reset_enter", {31'd0, scene_enter}, 0);
    check("reset_run",   {31'd0, timer_run}, 0);
    rst = 1'b0;
    step(5);

    // START -> PLAY on the 3rd sampling edge
    btn_start = 1'b1;
    step(2);
    check("start_not_yet", {28'd0, state}, 0);
    step(1);
    check("start_play",  {28'd0, state}, 1);
    check("start_enter", {31'd0, scene_enter}, 1);
    check("start_run",   {31'd0, timer_run}, 1);
    step(1);
    check("enter_once",  {31'd0, scene_enter}, 0);
    btn_start = 1'b0;
    step(3);

    // PLAY -> BOSS, then simultaneous death/boss_dead -> LOSE
    boss_zone = 1'b1; step(1); boss_zone = 1'b0;
    check("boss_entry", {28'd0, state}, 4);
    player_dead = 1'b1; boss_dead = 1'b1; step(1);
    player_dead = 1'b0; boss_dead = 1'b0;
    check("lose_priority", {28'd0, state}, 2);
    check("lose_run", {31'd0, timer_run}, 0);

    // Result timer: exactly CLK_HZ*RESULT_SEC cycles in LOSE
    step(19);
    check("lose_before_expiry", {28'd0, state}, 2);
    step(1);
    check("lose_expiry", {28'd0, state}, 0);
    check("expiry_enter", {31'd0, scene_enter}, 1);
    step(4);

    // WIN: early start edge ignored, later edge accepted
    to_win();
    check("win_entry", {28'd0, state}, 3);
    btn_start = 1'b1; step(3);
    check("win_early_ignored", {28'd0, state}, 3);
    step(2); btn_start = 1'b0; step(2);
    btn_start = 1'b1; step(3);
    check("win_start_exit", {28'd0, state}, 0);
    btn_start = 1'b0; step(2);

    // Reset in the middle of the WIN timer
    to_win();
    step(7);
    rst = 1'b1; #1;
    check("rst_win_state", {28'd0, state}, 0);
    check("rst_win_enter", {31'd0, scene_enter}, 0);
    check("rst_win_run",   {31'd0, timer_run}, 0);
    step(1); rst = 1'b0; step(3);
    press_start();
    player_dead = 1'b1; step(1); player_dead = 1'b0;
    step(19);
    check("timer_cleared_hold", {28'd0, state}, 2);
    step(1);
    check("timer_cleared_expiry", {28'd0, state}, 0);
    step(4);

    // Pause behaviour
    press_start();
    boss_zone = 1'b1; step(1); boss_zone = 1'b0;
    step(2);
    btn_pause = 1'b1; step(3); btn_pause = 1'b0;
    check("pause_enter", {28'd0, state}, PAUSE_EN ? 5 : 4);
    check("pause_run",   {31'd0, timer_run}, PAUSE_EN ? 0 : 1);
    player_dead = 1'b1; step(1); player_dead = 1'b0;
    check("pause_dead_ignored", {28'd0, state}, PAUSE_EN ? 5 : 2);
    step(2);
    if (PAUSE_EN) begin
      btn_pause = 1'b1; step(3); btn_pause = 1'b0;
      check("pause_resume", {28'd0, state}, 4);
      step(2);
      btn_pause = 1'b1; step(3); btn_pause = 1'b0;
      check("pause_again", {28'd0, state}, 5);
      step(2);
      rst = 1'b1; #1;
      check("rst_pause_state", {28'd0, state}, 0);
      step(1); rst = 1'b0;
    end
    step(3);

    // Randomized phase: fast buttons, then slow buttons to reach expiry
    for (int i = 0; i < 6000; i++) begin
      int bdiv;
      bdiv = (i < 3000) ? 5 : 60;
      if ($urandom_range(0, bdiv) == 0) btn_start = ~btn_start;
      if ($urandom_range(0, 9) == 0)    btn_pause = ~btn_pause;
      player_dead = ($urandom_range(0, 30) == 0);
      boss_zone   = ($urandom_range(0, 6) == 0);
      boss_dead   = ($urandom_range(0, 9) == 0);
      rst         = ($urandom_range(0, 499) == 0);
      step(1);
    end
    rst = 1'b0; player_dead = 1'b0; boss_zone = 1'b0; boss_dead = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/scene_ctrl.md
SCENE_CTRL -- requirements
Module: scene_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000: clk cycles per second.
REQ-002 SHALL have parameter RESULT_SEC, default 5: WIN/LOSE auto-return time in seconds.
REQ-003 SHALL have parameter HOLDOFF, default 1_000_000: cycles after scene entry during which button edges are ignored.
REQ-004 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port btn_start, input, 1: raw asynchronous start/confirm button.
REQ-007 SHALL have port btn_pause, input, 1: raw asynchronous pause button.
REQ-008 SHALL have port player_dead, input, 1: synchronous 1-cycle pulse.
REQ-009 SHALL have port boss_zone, input, 1: synchronous 1-cycle pulse, player reached boss area.
REQ-010 SHALL have port boss_dead, input, 1: synchronous 1-cycle pulse.
REQ-011 SHALL have port state, output, 4: registered scene code, consumed by the segment timer.
REQ-012 SHALL have port scene_enter, output, 1: 1-cycle pulse in the first cycle of every new scene value.
REQ-013 SHALL have port timer_run, output, 1: high only when state is PLAY or BOSS.

Function
REQ-014 SHALL use these encodings: START=0, PLAY=1, LOSE=2, WIN=3, BOSS=4, PAUSE=5; codes 6-15 never driven.
REQ-015 SHALL pass each button through a 2-flop synchronizer and a rising-edge detector, so state changes on the 3rd rising clk edge at which the button is sampled high.
REQ-016 SHALL ignore button edges while the holdoff counter is nonzero; the counter loads HOLDOFF-1 on every scene entry and decrements to 0.
REQ-017 SHALL move START -> PLAY on a start edge; all other inputs are ignored in START.
REQ-018 SHALL move PLAY -> LOSE on player_dead and PLAY -> BOSS on boss_zone; if both pulse together, LOSE wins.
REQ-019 SHALL move BOSS -> LOSE on player_dead and BOSS -> WIN on boss_dead; if both pulse together, LOSE wins.
REQ-020 SHALL move WIN or LOSE -> START on a start edge, or when the result timer expires, whichever comes first.
REQ-021 SHALL build the result timer from a prescaler (0..CLK_HZ-1) plus a seconds counter, both cleared on scene entry and counting only in WIN/LOSE; expiry is the cycle the seconds count reaches RESULT_SEC.
REQ-022 SHALL apply state transitions in the cycle after the triggering pulse is sampled (1-cycle latency for synchronous pulses).
REQ-023 SHALL assert scene_enter in the cycle state first shows its new value; self-transitions SHALL NOT occur.

Reset
REQ-024 SHALL, on rst, immediately set state=START, scene_enter=0, timer_run=0, clear synchronizers, edge history, prescaler and seconds counter, and set holdoff=HOLDOFF-1.
REQ-025 SHALL abandon any scene, including PAUSE, when reset is asserted mid-operation; no saved scene survives reset.

Configuration
REQ-026 SHALL compile the pause feature only when macro SCENE_PAUSE_EN is defined.
REQ-027 With SCENE_PAUSE_EN defined: a pause edge in PLAY or BOSS SHALL save the scene and enter PAUSE; in PAUSE, a pause edge SHALL return to the saved scene; player_dead, boss_zone, boss_dead and start edges are ignored in PAUSE; timer_run=0 in PAUSE.
REQ-028 With SCENE_PAUSE_EN undefined: btn_pause SHALL be unused, PAUSE SHALL never be produced, and no saved-scene register SHALL exist.

Structure
REQ-029 SHALL place scene encodings (scene_t) and the default parameter constants in shared package scene_pkg, which the segment timer also imports.
REQ-030 SHALL implement the synchronizer and edge detect as sub-module btn_edge, instantiated once per button.

Verification (CLK_HZ=10, RESULT_SEC=2, HOLDOFF=4)
REQ-031 Reset, then btn_start high once holdoff expires -> state 0->1 on the 3rd sampled edge; scene_enter pulses once; timer_run=1.
REQ-032 In PLAY, boss_zone pulse -> state=4 next cycle; then player_dead and boss_dead in the same cycle -> state=2.
REQ-033 In BOSS, boss_dead -> state=3; with no input for 20 cycles -> state=0 exactly at expiry; timer_run=0 throughout WIN.
REQ-034 Start edge within 4 cycles of entering WIN -> ignored; the same edge after holdoff -> START.
REQ-035 With SCENE_PAUSE_EN: in BOSS, pause edge -> 5; player_dead during PAUSE ignored; second pause edge -> 4.
REQ-036 rst asserted mid-PAUSE or mid-WIN timer -> state=0 with no clock edge; all counters cleared.
